chunk_head_arbiter: RTL
=======================

# chunk_head_arbiter

Two-source round-robin arbiter and issue stage in front of the DMA chunk-head address generator. It accepts block/alpha offset jobs from two requesters (source 0, source 1) and tags each job with its source as `which`. It attaches that source's config-id range `[beg, end)` and presents one registered job at a time to the chunk-head stage. Per-source credit counters bound the number of outstanding jobs per source until the downstream pipeline returns a completion.

## Interface
- WBW, TauCfg::WORK_BW: offset word width
- VDIM, TauCfg::VDIM: offset vector length
- N_ICFG, TauCfg::N_ICFG: number of config entries; ICFG_BW = $clog2(N_ICFG+1)
- CREDIT, 4: maximum outstanding jobs per source; CNT_BW = $clog2(CREDIT+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_abofs_rdy  in  [2]  per-source job valid
- i_abofs_ack  out  [2]  per-source job accepted; one-hot or zero
- i_bofs  in  [2][VDIM] x WBW  per-source block offsets
- i_aofs  in  [2][VDIM] x WBW  per-source alpha offsets
- i_beg, i_end  in  [2] x ICFG_BW  per-source config-id range (static while jobs pending)
- i_done_dval  in  1  completion pulse from downstream
- i_done_which  in  1  source of completed job
- o_abofs_rdy  out  1  registered job valid
- o_abofs_ack  in  1  downstream accepts job; only asserted while o_abofs_rdy
- o_which  out  1  source tag
- o_bofs, o_aofs  out  [VDIM] x WBW  registered offsets
- o_beg, o_end  out  ICFG_BW  registered config range
- o_busy  out  1  any credit counter nonzero or o_abofs_rdy

## Operation
- Output slot is one register; `load = (!o_abofs_rdy || o_abofs_ack) && (elig[0] || elig[1])`.
- `elig[s] = i_abofs_rdy[s] && (cnt[s] < CREDIT)`.
- Winner selection:
  - Only one source eligible: that source wins.
  - Both eligible: the source not equal to `last` wins.
- On load:
  - `i_abofs_ack[winner]=1` combinationally in the same cycle.
  - Slot captures the winner's bofs/aofs/beg/end, `o_which=winner`.
  - `last<=winner`; `cnt[winner]` increments.
- On `o_abofs_ack` without load: `o_abofs_rdy<=0`.
- Credits:
  - `i_done_dval` decrements `cnt[i_done_which]`.
  - Grant and done on the same source in the same cycle leave the counter unchanged.
  - Done on a zero counter is ignored; the counter stays 0.
  - Eligibility uses the registered count; a same-cycle done does not free a credit until the next cycle.
- Degenerate range `i_beg==i_end` is passed through unchanged; handling it is the chunk-head stage's concern.
- Reset values:
  - All outputs and counters are 0.
  - `last=1`, so source 0 wins the first tie.

## Timing
- Input ack to o_abofs_rdy: 1 cycle.
- Full throughput: a new job loads in the same cycle as `o_abofs_ack`, so back-to-back issue is one job per cycle.
- Outputs hold stable while `o_abofs_rdy && !o_abofs_ack`.
- Inputs must hold stable while `i_abofs_rdy[s]` is high and unacked.
- Reset mid-operation:
  - Slot and counters clear immediately (async).
  - In-flight downstream jobs are discarded.
  - Any done pulse after reset is treated as done on a zero counter.

## Configuration
- `CHUNK_ARB_CREDIT_EN` defined: credit counters, `i_done_*` and the `cnt<CREDIT` term are active as above.
- Undefined:
  - No counters; `elig[s]=i_abofs_rdy[s]`.
  - `i_done_*` is ignored.
  - `o_busy=o_abofs_rdy`.

## Structure
- Shared package (TauCfg): WORK_BW, VDIM, N_ICFG; add `CHUNK_ARB_CREDIT` as the default for CREDIT.
- Natural sub-module: `rr_arb2`, a combinational two-way round-robin pick with a registered `last` pointer. It takes `elig[2]` and `load`, and outputs `winner` and `any`.
- Top level holds the output slot register and the credit counters.

## Test plan
- Source 0 only, 3 jobs with bofs=1,2,3, o_abofs_ack always high -> o_which=0 and bofs 1,2,3 on consecutive cycles; cnt[0]=3.
- Both sources continuously ready, ack always high -> o_which alternates 0,1,0,1 starting at 0 after reset.
- CREDIT=4, no done, source 1 streams -> exactly 4 issues, then i_abofs_ack[1] stays 0. One done(which=1) -> exactly one more issue on the following cycle.
- o_abofs_ack held low 5 cycles with source 0 ready -> outputs constant, i_abofs_ack[0]=0 throughout. Ack then rises -> new job loads in that same cycle.
- Same-cycle grant and done for source 0 at cnt=2 -> cnt stays 2. Done with cnt[1]=0 -> cnt[1] stays 0.
- Assert rst while o_abofs_rdy=1 and cnt={3,2} -> o_abofs_rdy=0 and cnt={0,0} immediately. After reset, the first tie grants source 0.

Source files
------------

// File: rtl/chunk_head_arbiter_pkg.sv
// Shared configuration for the chunk-head arbiter: offset geometry, config-table
// size, default per-source credit depth and a small one-hot helper.
package chunk_head_arbiter_pkg;

   localparam int WORK_BW          = 32'd8;
   localparam int VDIM             = 32'd2;
   localparam int N_ICFG           = 32'd6;
   localparam int CHUNK_ARB_CREDIT = 32'd4;

   function automatic logic [1:0] onehot2(input logic sel);
      return sel ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/chunk_head_arbiter_rr_arb2.sv
// Two-way round-robin pick. The winner is combinational; the "last granted"
// pointer only advances on a load, so a stalled output never moves it.
module chunk_head_arbiter_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] elig,
   input  logic       load,
   output logic       winner,
   output logic       any
);

   logic last_r;

   // Winner select: a lone eligible source wins, a tie goes away from last_r
   always_comb begin
      winner = 1'b0;
      case (elig)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_r;
         default: winner = 1'b0;
      endcase
   end

   assign any = |elig;

   // Last-grant pointer; resets to 1 so source 0 wins the first tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_r <= 1'b1;
      end else if (load) begin
         last_r <= winner;
      end
   end

endmodule

// File: rtl/chunk_head_arbiter.sv
// Two-source round-robin issue stage feeding the DMA chunk-head generator.
// Define CHUNK_ARB_CREDIT_EN to enable per-source outstanding-job credits.
module chunk_head_arbiter #(
   parameter  int WBW     = chunk_head_arbiter_pkg::WORK_BW,
   parameter  int VDIM    = chunk_head_arbiter_pkg::VDIM,
   parameter  int N_ICFG  = chunk_head_arbiter_pkg::N_ICFG,
   parameter  int CREDIT  = chunk_head_arbiter_pkg::CHUNK_ARB_CREDIT,
   localparam int ICFG_BW = $clog2(N_ICFG + 1),
   localparam int CNT_BW  = $clog2(CREDIT + 1)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [1:0]                          i_abofs_rdy,
   output logic [1:0]                          i_abofs_ack,
   input  logic [1:0][VDIM-1:0][WBW-1:0]       i_bofs,
   input  logic [1:0][VDIM-1:0][WBW-1:0]       i_aofs,
   input  logic [1:0][ICFG_BW-1:0]             i_beg,
   input  logic [1:0][ICFG_BW-1:0]             i_end,
   input  logic                                i_done_dval,
   input  logic                                i_done_which,
   output logic                                o_abofs_rdy,
   input  logic                                o_abofs_ack,
   output logic                                o_which,
   output logic [VDIM-1:0][WBW-1:0]            o_bofs,
   output logic [VDIM-1:0][WBW-1:0]            o_aofs,
   output logic [ICFG_BW-1:0]                  o_beg,
   output logic [ICFG_BW-1:0]                  o_end,
   output logic                                o_busy
);
   import chunk_head_arbiter_pkg::*;

   logic [1:0] elig_s;
   logic       winner_s;
   logic       any_s;
   logic       load_s;

   assign load_s      = (!o_abofs_rdy || o_abofs_ack) && any_s;
   assign i_abofs_ack = load_s ? onehot2(winner_s) : 2'b00;

   chunk_head_arbiter_rr_arb2 u_rr (
      .clk    (clk),
      .rst    (rst),
      .elig   (elig_s),
      .load   (load_s),
      .winner (winner_s),
      .any    (any_s)
   );

`ifdef CHUNK_ARB_CREDIT_EN
   logic [1:0][CNT_BW-1:0] cnt_r;
   logic [1:0]             done_s;

   assign done_s = i_done_dval ? onehot2(i_done_which) : 2'b00;

   // Eligibility looks at the registered count only, so a done frees its credit next cycle
   always_comb begin
      elig_s = 2'b00;
      for (int s = 0; s < 2; s++) begin
         elig_s[s] = i_abofs_rdy[s] && (cnt_r[s] < CNT_BW'(CREDIT));
      end
   end

   // Credit counters: grant+done cancel, and a done against zero is dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (i_abofs_ack[s] && !done_s[s]) begin
               cnt_r[s] <= cnt_r[s] + CNT_BW'(1);
            end else if (!i_abofs_ack[s] && done_s[s] && (cnt_r[s] != '0)) begin
               cnt_r[s] <= cnt_r[s] - CNT_BW'(1);
            end
         end
      end
   end

   assign o_busy = o_abofs_rdy || (cnt_r[0] != '0) || (cnt_r[1] != '0);
`else
   logic unused_done_s;
   localparam int UNUSED_CREDIT_W = CREDIT + CNT_BW;

   assign elig_s        = i_abofs_rdy;
   assign unused_done_s = i_done_dval ^ i_done_which;
   assign o_busy        = o_abofs_rdy;
`endif

   // Output slot: refills on the same edge it is drained, giving one job per cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_abofs_rdy <= 1'b0;
         o_which     <= 1'b0;
         o_bofs      <= '0;
         o_aofs      <= '0;
         o_beg       <= '0;
         o_end       <= '0;
      end else if (load_s) begin
         o_abofs_rdy <= 1'b1;
         o_which     <= winner_s;
         o_bofs      <= i_bofs[winner_s];
         o_aofs      <= i_aofs[winner_s];
         o_beg       <= i_beg[winner_s];
         o_end       <= i_end[winner_s];
      end else if (o_abofs_ack) begin
         o_abofs_rdy <= 1'b0;
      end
   end

endmodule
